// File: rtl/muldiv_ctrl.sv
// Iterative 32-cycle multiply/divide sequencer for the EX stage.
// Owns HI/LO and raises stallMD while busy.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancel,
  input  logic             mdD,
  input  logic             mthiW,
  input  logic             mtloW,
  input  logic [WIDTH-1:0] wdataW,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stallMD
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t             state, state_nx;
  logic [CNTW-1:0]    cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   b;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;

  logic               sa_neg, sb_neg, div0, go;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_tr;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign busy    = (state != IDLE);
  assign stallMD = busy & mdD;

  assign go     = startE & ~cancel;
  assign div0   = opE[1] & (srcbE == '0);
  assign sa_neg = ~opE[0] & srcaE[WIDTH-1];
  assign sb_neg = ~opE[0] & srcbE[WIDTH-1];
  assign a_mag  = sa_neg ? -srcaE : srcaE;
  assign b_mag  = sb_neg ? -srcbE : srcbE;

  // Multiply: add multiplicand into upper half, shift right.
  assign mul_sum = {1'b0, acc_hi}
                 + (acc_lo[0] ? {1'b0, b} : '0);
  // Divide: shift in next dividend bit, trial subtract.
  assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_tr  = div_sh - {1'b0, b};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -acc_lo : acc_lo;
  assign r_fix    = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (go) state_nx = div0 ? FIX : CALC;
      CALC:
        if (cancel)           state_nx = IDLE;
        else if (cnt == LAST) state_nx = FIX;
      FIX:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      b      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mthiW) hi <= wdataW;
          if (mtloW) lo <= wdataW;
          if (go) begin
            cnt    <= '0;
            is_div <= opE[1];
            if (div0) begin
              // Preset divide-by-zero result; no sign fix.
              acc_hi <= srcaE;
              acc_lo <= '1;
              b      <= '0;
              neg_q  <= 1'b0;
              neg_r  <= 1'b0;
            end else begin
              acc_hi <= '0;
              acc_lo <= opE[1] ? a_mag : b_mag;
              b      <= opE[1] ? b_mag : a_mag;
              neg_q  <= sa_neg ^ sb_neg;
              neg_r  <= sa_neg;
            end
          end
        end
        CALC: begin
          if (cancel) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNTW'(1);
            if (is_div) begin
              acc_hi <= div_tr[WIDTH] ? div_sh[WIDTH-1:0]
                                      : div_tr[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], ~div_tr[WIDTH]};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          cnt <= '0;
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= r_fix;
              lo <= q_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table, random ops
// against an arithmetic reference, and stall/cancel/reset sequences.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE, srcbE;
  logic        cancel, mdD, mthiW, mtloW;
  logic [31:0] wdataW;
  logic [31:0] hi, lo;
  logic        busy, done, stallMD;

  int errors = 0;
  int checks = 0;
  int stall_bad = 0;

  muldiv_ctrl #(.WIDTH(32), .CNTW(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .startE  (startE),
    .opE     (opE),
    .srcaE   (srcaE),
    .srcbE   (srcbE),
    .cancel  (cancel),
    .mdD     (mdD),
    .mthiW   (mthiW),
    .mtloW   (mtloW),
    .wdataW  (wdataW),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stallMD (stallMD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic, returns {hi, lo}.
  function automatic logic [63:0] ref_md(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin
        p = sa * sb;
        return p;
      end
      2'd1: begin
        u = {32'b0, a} * {32'b0, b};
        return u;
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cyc);
    startE = 1'b1;
    opE    = op;
    srcaE  = a;
    srcbE  = b;
    step();
    startE = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (mdD && !stallMD) stall_bad++;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dcount;
    logic [63:0] e;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vt[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 33};
    vt[1] = '{2'd0, 32'hFFFF_FFFD, 32'd7,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
    vt[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vt[3] = '{2'd3, 32'd100, 32'd0,
              32'd100, 32'hFFFF_FFFF, 1};
    vt[4] = '{2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33};
    vt[5] = '{2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 33};
    vt[6] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000, 33};
    vt[7] = '{2'd2, 32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD, 33};
    vt[8] = '{2'd0, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'd0, 33};
    vt[9] = '{2'd2, 32'hFFFF_FFFB, 32'd0,
              32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};

    reset_n = 1'b0;
    startE = 0; opE = 0; srcaE = 0; srcbE = 0;
    cancel = 0; mdD = 1; mthiW = 0; mtloW = 0; wdataW = 0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("idle stallMD", 32'(stallMD), 32'd0);
    mdD = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, cyc);
      chk($sformatf("vec%0d busy cycles", i), cyc, vt[i].cyc);
      chk($sformatf("vec%0d hi", i), hi, vt[i].hi);
      chk($sformatf("vec%0d lo", i), lo, vt[i].lo);
      chk($sformatf("vec%0d done", i), 32'(done), 32'd1);
      step();
      chk($sformatf("vec%0d done clr", i), 32'(done), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      e = ref_md(rop, ra, rb);
      run_op(rop, ra, rb, cyc);
      chk($sformatf("rnd%0d op%0d cycles", i, rop), cyc,
          (rop[1] && rb == 0) ? 32'd1 : 32'd33);
      chk($sformatf("rnd%0d op%0d %h,%h hi", i, rop, ra, rb),
          hi, e[63:32]);
      chk($sformatf("rnd%0d op%0d %h,%h lo", i, rop, ra, rb),
          lo, e[31:0]);
      step();
    end

    // Stall toward hazard unit while busy.
    mdD = 1'b1;
    stall_bad = 0;
    run_op(2'd3, 32'd100, 32'd7, cyc);
    chk("stall busy cycles", cyc, 32'd33);
    chk("stall missing", stall_bad, 32'd0);
    chk("stall after fix", 32'(stallMD), 32'd0);
    chk("stall divu lo", lo, 32'd14);
    chk("stall divu hi", hi, 32'd2);
    mdD = 1'b0;
    step();

    // Cancel mid-CALC preserves HI/LO set by MTHI/MTLO.
    mthiW = 1'b1; wdataW = 32'h1234;
    step();
    mthiW = 1'b0; mtloW = 1'b1; wdataW = 32'h5678;
    step();
    mtloW = 1'b0;
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h5678);
    startE = 1'b1; opE = 2'd1;
    srcaE = 32'hFFFF_FFFF; srcbE = 32'd3;
    step();
    startE = 1'b0;
    repeat (10) step();
    chk("pre-cancel busy", 32'(busy), 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel busy", 32'(busy), 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dcount++;
      step();
    end
    chk("cancel no done", dcount, 32'd0);
    chk("cancel hi", hi, 32'h1234);
    chk("cancel lo", lo, 32'h5678);

    // Asynchronous reset mid-CALC.
    startE = 1'b1; opE = 2'd1; srcaE = 32'd5; srcbE = 32'd5;
    step();
    startE = 1'b0;
    repeat (5) step();
    #3 reset_n = 1'b0;
    #1;
    chk("areset hi", hi, 32'd0);
    chk("areset lo", lo, 32'd0);
    chk("areset busy", 32'(busy), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    run_op(2'd1, 32'd6, 32'd7, cyc);
    chk("post-reset cycles", cyc, 32'd33);
    chk("post-reset lo", lo, 32'd42);
    chk("post-reset hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for an iterative 32-cycle multiply/divide unit in the EX stage of the five-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs shift-add or restoring-divide iterations.
- Owns the HI/LO registers and asserts a stall toward the hazard unit whenever a decode-stage instruction needs HI/LO or the unit while it is busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- startE  input  1  EX-stage mult/div instruction valid
- opE  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- srcaE  input  WIDTH  rs operand (multiplicand / dividend)
- srcbE  input  WIDTH  rt operand (multiplier / divisor)
- cancel  input  1  abort the in-flight operation (exception flush)
- mdD  input  1  decode-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- mthiW  input  1  writeback-stage MTHI
- mtloW  input  1  writeback-stage MTLO
- wdataW  input  WIDTH  MTHI/MTLO data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse after HI/LO are updated by an operation
- stallMD  output  1  stall request to the hazard unit (ORed into stallF/stallD/flushE there)

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; hi=0, lo=0, busy=0, done=0, counter=0; internal accumulators cleared.
- States: IDLE, CALC, FIX.
- IDLE:
  - startE=1 with cancel=0 latches operands. For signed ops, latch magnitudes and record result sign bits (product/quotient negative iff operand signs differ; remainder takes the dividend's sign).
  - Then go to CALC with counter=0.
  - startE=1 with cancel=1: ignored.
- Division by zero (DIV/DIVU with srcbE=0): skip CALC and go directly to FIX with preset results quotient=all ones, remainder=srcaE (raw, unsigned interpretation). FIX applies no sign correction in this case.
- CALC:
  - One iteration per cycle.
  - Multiply: 2*WIDTH-bit shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring algorithm, one quotient bit per cycle, MSB first; remainder kept WIDTH+1 bits wide for the trial subtract.
  - Counter increments each cycle. After the iteration with counter=WIDTH-1, go to FIX.
- FIX:
  - Apply sign correction (two's-complement negate of product, quotient and/or remainder per the recorded bits).
  - Write HI/LO: multiply gives hi=product[2W-1:W], lo=product[W-1:0]; divide gives hi=remainder, lo=quotient.
  - Go to IDLE. done=1 in the following cycle only.
- Latency: startE sampled at edge N, so HI/LO are valid after edge N+WIDTH+1 (edge N+33 for WIDTH=32). For divide-by-zero, HI/LO are valid after edge N+1.
- busy=1 in CALC and FIX; 0 in IDLE.
- stallMD = busy & mdD, combinational. Not asserted in IDLE.
- cancel=1 in CALC or FIX: go to IDLE at the next edge. HI/LO are unchanged, no done pulse, counter cleared. cancel has priority over the FIX write.
- MTHI/MTLO:
  - In IDLE, mthiW writes hi=wdataW and mtloW writes lo=wdataW at the edge; both may fire in the same cycle.
  - If busy, mthiW/mtloW are ignored. The hazard unit guarantees this cannot occur legally.
  - An FIX write in the same cycle as mthiW/mtloW cannot occur (FIX implies busy); the FIX write wins regardless.
- startE while busy: ignored. stallMD has already held the instruction in decode.
- Overflow: none flagged. MULT/DIV never trap. DIV of most-negative by -1 yields lo=most-negative, hi=0.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done pulses once; busy high for exactly 33 cycles.
- MULT -3 * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> next cycle lo=0xFFFFFFFF, hi=100; busy high one cycle.
- Start DIVU 100 / 7, assert mdD during busy -> stallMD=1 each busy cycle, 0 in the cycle after FIX; final lo=14, hi=2.
- Start MULTU, assert cancel at CALC cycle 10 -> busy drops next edge; hi/lo keep their prior values (set via mthiW/mtloW to 0x1234/0x5678 beforehand); no done pulse.
- Pulse reset_n low mid-CALC, asynchronously (not edge-aligned) -> hi=lo=0, busy=0 immediately; a new MULTU 6*7 afterward gives lo=42, hi=0.
